// File: rtl/pb_io_router.sv
// PicoBlaze I/O port router: decodes port_id into input and output channels,
// registers read data, read acks and write enables, and aggregates edge-triggered interrupts.
module pb_io_router #(
    parameter int         N_IN      = 4,
    parameter int         N_OUT     = 4,
    parameter logic [7:0] IN_BASE   = 8'h00,
    parameter logic [7:0] OUT_BASE  = 8'h00,
    parameter int         IRQ_N     = 4,
    parameter logic [7:0] MASK_PORT = 8'hF1,
    parameter logic [7:0] PEND_PORT = 8'hF2
) (
    input  logic                clk,
    input  logic                pb_reset,
    input  logic [7:0]          port_id,
    input  logic                read_strobe,
    input  logic                write_strobe,
    input  logic [7:0]          out_port,
    output logic [7:0]          in_port,
    output logic                interrupt,
    input  logic                interrupt_ack,
    input  logic [8*N_IN-1:0]   in_data,
    output logic [N_IN-1:0]     rd_ack,
    output logic [N_OUT-1:0]    wr_en,
    output logic [7:0]          wr_data,
    input  logic [IRQ_N-1:0]    irq_src
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_SERVICE
    } irqState_t;

    irqState_t state_q, state_d;

    logic [7:0]       in_port_q, in_port_d;
    logic [N_IN-1:0]  rd_ack_q, rd_ack_d;
    logic [N_OUT-1:0] wr_en_q, wr_en_d;
    logic [7:0]       wr_data_q;
    logic [IRQ_N-1:0] mask_q;
    logic [IRQ_N-1:0] pending_q, pending_d;
    logic [IRQ_N-1:0] irq_prev_q;

    logic             isMask;
    logic             isPend;
    logic             maskWrite;
    logic             pendWrite;
    logic [N_IN-1:0]  inHit;
    logic [N_OUT-1:0] outHit;
    logic [7:0]       maskExt;
    logic [7:0]       pendExt;
    logic [IRQ_N-1:0] irqRise;
    logic [IRQ_N-1:0] pendClear;

    // Channel sums are 9 bits wide so a channel past 8'hFF can never alias a low port;
    // the internal registers shadow any channel that lands on their address.
    always_comb begin
        isMask = (port_id == MASK_PORT);
        isPend = (port_id == PEND_PORT) && !isMask;
        inHit  = '0;
        outHit = '0;
        for (int i = 0; i < N_IN; i++) begin
            inHit[i] = !isMask && !isPend &&
                       ({1'b0, port_id} == ({1'b0, IN_BASE} + 9'(i)));
        end
        for (int k = 0; k < N_OUT; k++) begin
            outHit[k] = !isMask && !isPend &&
                        ({1'b0, port_id} == ({1'b0, OUT_BASE} + 9'(k)));
        end
    end

    always_comb begin
        maskExt                = '0;
        maskExt[IRQ_N-1:0]     = mask_q;
        pendExt                = '0;
        pendExt[IRQ_N-1:0]     = pending_q;
        in_port_d              = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (inHit[i]) begin
                in_port_d = in_data[8*i +: 8];
            end
        end
        if (isPend) begin
            in_port_d = pendExt;
        end
        if (isMask) begin
            in_port_d = maskExt;
        end
        rd_ack_d = inHit & {N_IN{read_strobe}};
        wr_en_d  = outHit & {N_OUT{write_strobe}};
    end

    // A new edge beats a simultaneous write-1-to-clear so no interrupt is ever lost.
    always_comb begin
        maskWrite = write_strobe && isMask;
        pendWrite = write_strobe && isPend;
        irqRise   = irq_src & ~irq_prev_q;
        pendClear = pendWrite ? out_port[IRQ_N-1:0] : '0;
        pending_d = (pending_q & ~pendClear) | irqRise;
    end

    always_ff @(posedge clk or posedge pb_reset) begin
        if (pb_reset) begin
            in_port_q  <= '0;
            rd_ack_q   <= '0;
            wr_en_q    <= '0;
            wr_data_q  <= '0;
            mask_q     <= '0;
            pending_q  <= '0;
            irq_prev_q <= '0;
        end else begin
            in_port_q  <= in_port_d;
            rd_ack_q   <= rd_ack_d;
            wr_en_q    <= wr_en_d;
            irq_prev_q <= irq_src;
            pending_q  <= pending_d;
            if (write_strobe) begin
                wr_data_q <= out_port;
            end
            if (maskWrite) begin
                mask_q <= out_port[IRQ_N-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge pb_reset) begin
        if (pb_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Once raised, interrupt stays up until acknowledged, even if the mask changes;
    // SERVICE waits for the ISR's pending-clear write before re-arming.
    always_comb begin
        state_d   = state_q;
        interrupt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((pending_q & mask_q) != '0) begin
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                interrupt = 1'b1;
                if (interrupt_ack) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (pendWrite) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_port = in_port_q;
    assign rd_ack  = rd_ack_q;
    assign wr_en   = wr_en_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_pb_io_router.sv
// Directed bench for pb_io_router: a default-style instance plus a second one whose
// channels straddle the internal registers and the 8'hFF address boundary.
module tb_pb_io_router;

    logic        clk;
    logic        pbReset;
    logic [7:0]  portId;
    logic        readStrobe;
    logic        writeStrobe;
    logic [7:0]  outPort;
    logic        interruptAck;

    logic [31:0] inData;
    logic [3:0]  irqSrc;
    logic [7:0]  inPort;
    logic        irqOut;
    logic [3:0]  rdAck;
    logic [3:0]  wrEn;
    logic [7:0]  wrData;

    logic [31:0] inData2;
    logic [7:0]  irqSrc2;
    logic [7:0]  inPort2;
    logic        irqOut2;
    logic [3:0]  rdAck2;
    logic [3:0]  wrEn2;
    logic [7:0]  wrData2;

    int testsRun = 0;
    int failures = 0;

    pb_io_router #(
        .N_IN(4), .N_OUT(4), .IN_BASE(8'h00), .OUT_BASE(8'h01),
        .IRQ_N(4), .MASK_PORT(8'hF1), .PEND_PORT(8'hF2)
    ) dut (
        .clk(clk), .pb_reset(pbReset), .port_id(portId),
        .read_strobe(readStrobe), .write_strobe(writeStrobe), .out_port(outPort),
        .in_port(inPort), .interrupt(irqOut), .interrupt_ack(interruptAck),
        .in_data(inData), .rd_ack(rdAck), .wr_en(wrEn), .wr_data(wrData),
        .irq_src(irqSrc)
    );

    pb_io_router #(
        .N_IN(4), .N_OUT(4), .IN_BASE(8'hF0), .OUT_BASE(8'hFE),
        .IRQ_N(8), .MASK_PORT(8'hF1), .PEND_PORT(8'hF2)
    ) dut2 (
        .clk(clk), .pb_reset(pbReset), .port_id(portId),
        .read_strobe(readStrobe), .write_strobe(writeStrobe), .out_port(outPort),
        .in_port(inPort2), .interrupt(irqOut2), .interrupt_ack(interruptAck),
        .in_data(inData2), .rd_ack(rdAck2), .wr_en(wrEn2), .wr_data(wrData2),
        .irq_src(irqSrc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] pid, input logic rs,
                                 input logic ws, input logic [7:0] data);
        portId      = pid;
        readStrobe  = rs;
        writeStrobe = ws;
        outPort     = data;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        pbReset      = 1'b1;
        interruptAck = 1'b0;
        irqSrc       = 4'b0000;
        irqSrc2      = 8'h00;
        inData       = 32'h44A5_2211;
        inData2      = 32'hD3C2_B1A0;
        applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        checkOutput("reset in_port", {8'h0, inPort}, 16'h0000);
        checkOutput("reset rd_ack", {12'h0, rdAck}, 16'h0000);
        checkOutput("reset wr_en", {12'h0, wrEn}, 16'h0000);
        checkOutput("reset wr_data", {8'h0, wrData}, 16'h0000);
        checkOutput("reset interrupt", {15'h0, irqOut}, 16'h0000);
        pbReset = 1'b0;
        tick();

        // Reads: channel mux, single-cycle rd_ack, unmapped port
        applyStimulus(8'h02, 1'b0, 1'b0, 8'h00);
        tick();
        checkOutput("read ch2 data", {8'h0, inPort}, 16'h00A5);
        checkOutput("no ack without strobe", {12'h0, rdAck}, 16'h0000);
        applyStimulus(8'h02, 1'b1, 1'b0, 8'h00);
        tick();
        checkOutput("rd_ack ch2", {12'h0, rdAck}, 16'h0004);
        applyStimulus(8'h02, 1'b0, 1'b0, 8'h00);
        tick();
        checkOutput("rd_ack one cycle", {12'h0, rdAck}, 16'h0000);
        applyStimulus(8'h40, 1'b0, 1'b0, 8'h00);
        tick();
        checkOutput("unmapped read", {8'h0, inPort}, 16'h0000);
        applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
        tick();
        checkOutput("read ch0 data", {8'h0, inPort}, 16'h0011);
        checkOutput("rd_ack ch0", {12'h0, rdAck}, 16'h0001);
        checkOutput("dut2 no wrap read", {8'h0, inPort2}, 16'h0000);
        checkOutput("dut2 no wrap rd_ack", {12'h0, rdAck2}, 16'h0000);
        applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
        tick();

        // Writes: channel decode, wr_data hold, register ports shadow channels
        applyStimulus(8'h03, 1'b0, 1'b1, 8'h3C);
        tick();
        checkOutput("wr_en ch2", {12'h0, wrEn}, 16'h0004);
        checkOutput("wr_data 3C", {8'h0, wrData}, 16'h003C);
        applyStimulus(8'h03, 1'b0, 1'b0, 8'h00);
        tick();
        checkOutput("wr_en one cycle", {12'h0, wrEn}, 16'h0000);
        checkOutput("wr_data hold", {8'h0, wrData}, 16'h003C);
        applyStimulus(8'hF1, 1'b0, 1'b1, 8'h01);
        tick();
        checkOutput("mask write no wr_en", {12'h0, wrEn}, 16'h0000);
        checkOutput("mask write wr_data", {8'h0, wrData}, 16'h0001);
        applyStimulus(8'hF1, 1'b1, 1'b0, 8'h00);
        tick();
        checkOutput("mask readback", {8'h0, inPort}, 16'h0001);
        checkOutput("mask read no rd_ack", {12'h0, rdAck}, 16'h0000);
        checkOutput("dut2 mask shadows ch1", {8'h0, inPort2}, 16'h0001);
        checkOutput("dut2 mask no rd_ack", {12'h0, rdAck2}, 16'h0000);
        applyStimulus(8'hF3, 1'b1, 1'b0, 8'h00);
        tick();
        checkOutput("dut2 read ch3", {8'h0, inPort2}, 16'h00D3);
        checkOutput("dut2 rd_ack ch3", {12'h0, rdAck2}, 16'h0008);
        applyStimulus(8'hFF, 1'b0, 1'b1, 8'h77);
        tick();
        checkOutput("dut2 wr_en at FF", {12'h0, wrEn2}, 16'h0002);
        checkOutput("dut1 no wr_en at FF", {12'h0, wrEn}, 16'h0000);
        applyStimulus(8'h01, 1'b0, 1'b1, 8'h55);
        tick();
        checkOutput("dut1 wr_en ch0", {12'h0, wrEn}, 16'h0001);
        checkOutput("dut2 no wrap write", {12'h0, wrEn2}, 16'h0000);
        applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
        tick();

        // Single source: edge -> pending -> interrupt -> ack -> clear
        applyStimulus(8'hF2, 1'b0, 1'b0, 8'h00);
        irqSrc = 4'b0001;
        tick();
        checkOutput("irq not yet", {15'h0, irqOut}, 16'h0000);
        tick();
        checkOutput("irq raised", {15'h0, irqOut}, 16'h0001);
        checkOutput("pending bit0", {8'h0, inPort}, 16'h0001);
        interruptAck = 1'b1;
        tick();
        interruptAck = 1'b0;
        checkOutput("irq dropped on ack", {15'h0, irqOut}, 16'h0000);
        tick();
        checkOutput("service holds low", {15'h0, irqOut}, 16'h0000);
        applyStimulus(8'hF2, 1'b0, 1'b1, 8'h01);
        tick();
        applyStimulus(8'hF2, 1'b0, 1'b0, 8'h00);
        checkOutput("irq low after clear", {15'h0, irqOut}, 16'h0000);
        tick();
        checkOutput("pending cleared", {8'h0, inPort}, 16'h0000);
        tick();
        checkOutput("irq stays low", {15'h0, irqOut}, 16'h0000);
        checkOutput("dut2 no irq", {15'h0, irqOut2}, 16'h0000);

        // Two sources, ISR clears only one: re-assert two cycles after the write
        applyStimulus(8'hF1, 1'b0, 1'b1, 8'h03);
        irqSrc = 4'b0000;
        tick();
        applyStimulus(8'hF2, 1'b0, 1'b0, 8'h00);
        irqSrc = 4'b0011;
        tick();
        tick();
        checkOutput("irq two sources", {15'h0, irqOut}, 16'h0001);
        interruptAck = 1'b1;
        tick();
        interruptAck = 1'b0;
        checkOutput("irq acked", {15'h0, irqOut}, 16'h0000);
        applyStimulus(8'hF2, 1'b0, 1'b1, 8'h01);
        tick();
        applyStimulus(8'hF2, 1'b0, 1'b0, 8'h00);
        checkOutput("irq low t+1", {15'h0, irqOut}, 16'h0000);
        tick();
        checkOutput("irq reasserts t+2", {15'h0, irqOut}, 16'h0001);
        checkOutput("pending bit1 left", {8'h0, inPort}, 16'h0002);
        interruptAck = 1'b1;
        tick();
        interruptAck = 1'b0;
        applyStimulus(8'hF2, 1'b0, 1'b1, 8'h02);
        tick();
        applyStimulus(8'hF2, 1'b0, 1'b0, 8'h00);
        tick();
        checkOutput("all cleared", {8'h0, inPort}, 16'h0000);
        checkOutput("irq idle", {15'h0, irqOut}, 16'h0000);

        // Edge coinciding with a clear of the same bit: set wins
        irqSrc = 4'b0000;
        tick();
        irqSrc = 4'b0001;
        tick();
        irqSrc = 4'b0000;
        tick();
        irqSrc = 4'b0001;
        applyStimulus(8'hF2, 1'b0, 1'b1, 8'h01);
        tick();
        applyStimulus(8'hF2, 1'b0, 1'b0, 8'h00);
        tick();
        checkOutput("set beats clear", {8'h0, inPort}, 16'h0001);
        checkOutput("irq asserted", {15'h0, irqOut}, 16'h0001);

        // Asynchronous reset mid-handshake, then a masked-out source
        #2;
        pbReset = 1'b1;
        #1;
        checkOutput("async reset irq", {15'h0, irqOut}, 16'h0000);
        checkOutput("async reset in_port", {8'h0, inPort}, 16'h0000);
        applyStimulus(8'hF1, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        pbReset = 1'b0;
        tick();
        checkOutput("mask after reset", {8'h0, inPort}, 16'h0000);
        applyStimulus(8'hF2, 1'b0, 1'b0, 8'h00);
        irqSrc = 4'b0011;
        tick();
        checkOutput("pending set on first clock", {8'h0, inPort}, 16'h0001);
        tick();
        checkOutput("pending both masked out", {8'h0, inPort}, 16'h0003);
        checkOutput("no irq when masked", {15'h0, irqOut}, 16'h0000);
        tick();
        checkOutput("still no irq", {15'h0, irqOut}, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
